// File: rtl/lcd_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_pkg
// Purpose  : Shared command codes, host FSM encoding and default sizes for
//            the LCD host driver.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam logic [2:0] CMD_REFRESH  = 3'd0;
  localparam logic [2:0] CMD_LOAD     = 3'd1;
  localparam logic [2:0] CMD_ZOOM_IN  = 3'd2;
  localparam logic [2:0] CMD_ZOOM_OUT = 3'd3;
  localparam logic [2:0] CMD_SHIFT_R  = 3'd4;
  localparam logic [2:0] CMD_SHIFT_L  = 3'd5;
  localparam logic [2:0] CMD_SHIFT_U  = 3'd6;
  localparam logic [2:0] CMD_SHIFT_D  = 3'd7;

  localparam int DEF_IMG_PIXELS = 64;
  localparam int DEF_WIN_PIXELS = 16;
  localparam int DEF_TIMEOUT    = 1023;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_COLLECT = 3'd3,
    ST_SETTLE  = 3'd4
  } host_state_e;

endpackage
`default_nettype wire

// File: rtl/lcd_pix_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_pix_capture
// Purpose  : Pixel counter and frame-buffer write port for one response
//            window; flags the last pixel and ignores strobes once full.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_pix_capture import lcd_pkg::*; #(
  parameter int WIN_PIXELS = DEF_WIN_PIXELS,
  parameter int PAW        = $clog2(WIN_PIXELS)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           en_i,
  input  logic           clr_i,
  input  logic           output_valid_i,
  input  logic [7:0]     dataout_i,
  output logic           pix_we_o,
  output logic [PAW-1:0] pix_addr_o,
  output logic [7:0]     pix_data_o,
  output logic           last_o,
  output logic           full_o
);

  localparam logic [PAW-1:0] LAST_PIX = PAW'(WIN_PIXELS - 1);

  logic [PAW-1:0] cnt_q;
  logic           full_q;

  assign pix_we_o   = en_i && output_valid_i && !full_q;
  assign pix_addr_o = cnt_q;
  assign pix_data_o = pix_we_o ? dataout_i : 8'h00;
  assign last_o     = pix_we_o && (cnt_q == LAST_PIX);
  assign full_o     = full_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else if (pix_we_o) begin
      cnt_q  <= last_o ? '0 : cnt_q + 1'b1;
      full_q <= last_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_host_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_host_driver
// Purpose  : Issues LCD commands, streams image bytes for LOAD and captures
//            the returned pixel window, with a response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_host_driver import lcd_pkg::*; #(
  parameter int IMG_PIXELS = DEF_IMG_PIXELS,
  parameter int WIN_PIXELS = DEF_WIN_PIXELS,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int IAW        = $clog2(IMG_PIXELS),
  parameter int PAW        = $clog2(WIN_PIXELS)
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           req_valid_i,
  input  logic [2:0]     req_cmd_i,
  output logic           req_ready_o,
  output logic [IAW-1:0] img_addr_o,
  input  logic [7:0]     img_data_i,
  output logic [2:0]     cmd_o,
  output logic           cmd_valid_o,
  output logic [7:0]     datain_o,
  input  logic           busy_i,
  input  logic [7:0]     dataout_i,
  input  logic           output_valid_i,
  output logic           pix_we_o,
  output logic [PAW-1:0] pix_addr_o,
  output logic [7:0]     pix_data_o,
  output logic           done_o,
  output logic           err_timeout_o
);

  localparam int TAW = $clog2(TIMEOUT + 1);
  localparam logic [IAW-1:0] LAST_BYTE = IAW'(IMG_PIXELS - 1);
  localparam logic [TAW-1:0] TO_LAST   = TAW'(TIMEOUT - 1);

  host_state_e    state_q;
  logic [2:0]     cmd_q;
  logic           cmd_valid_q;
  logic [IAW-1:0] img_addr_q;
  logic [IAW-1:0] load_cnt_q;
  logic [TAW-1:0] to_cnt_q;
  logic           done_q;
  logic           err_q;

  logic accept;
  logic waiting;
  logic timeout_hit;
  logic pix_last;
  logic pix_full;

  assign req_ready_o = (state_q == ST_IDLE) && !busy_i;
  assign accept      = req_valid_i && req_ready_o;
  assign waiting     = (state_q == ST_COLLECT) || (state_q == ST_SETTLE);
  assign timeout_hit = waiting && (to_cnt_q == TO_LAST);

  // ROM data is a cycle behind the address, so it is forwarded untouched
  assign datain_o      = (state_q == ST_LOAD) ? img_data_i : 8'h00;
  assign img_addr_o    = img_addr_q;
  assign cmd_o         = cmd_q;
  assign cmd_valid_o   = cmd_valid_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_q;

  lcd_pix_capture #(
    .WIN_PIXELS (WIN_PIXELS),
    .PAW        (PAW)
  ) u_capture (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .en_i           (state_q == ST_COLLECT),
    .clr_i          (accept || timeout_hit),
    .output_valid_i (output_valid_i),
    .dataout_i      (dataout_i),
    .pix_we_o       (pix_we_o),
    .pix_addr_o     (pix_addr_o),
    .pix_data_o     (pix_data_o),
    .last_o         (pix_last),
    .full_o         (pix_full)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 3'd0;
      cmd_valid_q <= 1'b0;
      img_addr_q  <= '0;
      load_cnt_q  <= '0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_q       <= req_cmd_i;
            cmd_valid_q <= 1'b1;
            img_addr_q  <= '0;
            load_cnt_q  <= '0;
            to_cnt_q    <= '0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cmd_q == CMD_LOAD) begin
            img_addr_q <= img_addr_q + 1'b1;
            state_q    <= ST_LOAD;
          end else begin
            state_q    <= ST_COLLECT;
          end
        end
        ST_LOAD: begin
          img_addr_q <= (img_addr_q == LAST_BYTE) ? img_addr_q : img_addr_q + 1'b1;
          load_cnt_q <= load_cnt_q + 1'b1;
          if (load_cnt_q == LAST_BYTE) begin
            state_q <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (pix_last) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          to_cnt_q <= to_cnt_q + 1'b1;
          if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (!busy_i) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Full flag is consumed only inside the capture block's write gating
  logic unused_ok;
  assign unused_ok = pix_full;

endmodule
`default_nettype wire

// File: tb/tb_lcd_host_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lcd_host_driver
// Purpose  : Self-checking bench pairing the host driver with a behavioural
//            LCD controller (8x8 image, 4x4 window) and a ROM where byte k = k.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_host_driver;
  import lcd_pkg::*;

  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_cmd = 3'd0;
  logic       req_ready;
  logic [5:0] img_addr;
  logic [7:0] img_data = 8'h00;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy = 1'b0;
  logic [7:0] dataout = 8'h00;
  logic       m_ov = 1'b0;
  logic       spur_ov = 1'b0;
  logic       pix_we;
  logic [3:0] pix_addr;
  logic [7:0] pix_data;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  lcd_host_driver #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .req_valid_i    (req_valid),
    .req_cmd_i      (req_cmd),
    .req_ready_o    (req_ready),
    .img_addr_o     (img_addr),
    .img_data_i     (img_data),
    .cmd_o          (cmd),
    .cmd_valid_o    (cmd_valid),
    .datain_o       (datain),
    .busy_i         (busy),
    .dataout_i      (dataout),
    .output_valid_i (m_ov | spur_ov),
    .pix_we_o       (pix_we),
    .pix_addr_o     (pix_addr),
    .pix_data_o     (pix_data),
    .done_o         (done),
    .err_timeout_o  (err)
  );

  always @(posedge clk) img_data <= {2'b00, img_addr};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Negedge monitor: pulse counters and frame buffer (cleared on each new command)
  int cyc = 0, cv_cyc = 0;
  int n_cv = 0, n_done = 0, n_we = 0, rdy_viol = 0;
  logic [7:0] fb [16];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cv++;
      cv_cyc = cyc;
      for (int i = 0; i < 16; i++) fb[i] = 8'hFF;
    end
    if (done) n_done++;
    if (pix_we) begin
      fb[pix_addr] = pix_data;
      n_we++;
    end
    if (busy && req_ready) rdy_viol++;
  end

  // Behavioural LCD controller
  int ph = 0, k = 0, mc = 0, p = 0;
  int m_npix = 16;
  int load_err = 0, load_n = 0;
  logic [2:0] m_cmd = 3'd0;
  logic [7:0] img [64];
  bit zoomed = 1'b0;
  int mx = 2, my = 2;
  int cmd_log [$];

  function automatic logic [7:0] win_px(input int idx);
    int i, j;
    i = idx / 4;
    j = idx % 4;
    if (idx > 15) return 8'hEE;
    if (zoomed) return img[(my + i) * 8 + mx + j];
    return img[(2 * i) * 8 + 2 * j];
  endfunction

  task automatic apply_cmd(input logic [2:0] c);
    case (c)
      CMD_LOAD:     begin zoomed = 1'b0; mx = 2; my = 2; end
      CMD_ZOOM_IN:  zoomed = 1'b1;
      CMD_ZOOM_OUT: zoomed = 1'b0;
      CMD_SHIFT_R:  if (zoomed && mx < 4) mx++;
      CMD_SHIFT_L:  if (zoomed && mx > 0) mx--;
      CMD_SHIFT_U:  if (zoomed && my > 0) my--;
      CMD_SHIFT_D:  if (zoomed && my < 4) my++;
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    forever begin
      @(posedge clk); #2;
      if (reset) begin
        ph = 0; busy = 1'b0; m_ov = 1'b0; dataout = 8'h00;
      end else begin
        m_ov = 1'b0;
        case (ph)
          0: if (cmd_valid) begin
               m_cmd = cmd;
               cmd_log.push_back(int'(cmd));
               busy = 1'b1;
               if (cmd == CMD_LOAD) begin ph = 1; k = 0; end
               else begin ph = 2; mc = 3; end
             end
          1: begin
               img[k] = datain;
               load_n++;
               if (int'(datain) != k) load_err++;
               k++;
               if (k == 64) begin ph = 2; mc = 3; end
             end
          2: begin
               mc--;
               if (mc == 0) begin apply_cmd(m_cmd); ph = 3; p = 0; end
             end
          3: if (p >= m_npix) begin ph = 4; mc = 2; end
             else begin m_ov = 1'b1; dataout = win_px(p); p++; end
          4: begin
               mc--;
               if (mc == 0) begin busy = 1'b0; ph = 0; end
             end
          default: ph = 0;
        endcase
      end
    end
  end

  task automatic send_req(input logic [2:0] c, output bit ok);
    ok = 1'b0;
    @(posedge clk); #1;
    req_cmd = c;
    req_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_end(input int d0, input logic e0, output bit got);
    got = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n_done != d0 || err !== e0) begin got = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " cmd"}, int'(cmd), 0);
    check({tag, " cmd_valid"}, int'(cmd_valid), 0);
    check({tag, " datain"}, int'(datain), 0);
    check({tag, " img_addr"}, int'(img_addr), 0);
    check({tag, " pix_we"}, int'(pix_we), 0);
    check({tag, " pix_addr"}, int'(pix_addr), 0);
    check({tag, " pix_data"}, int'(pix_data), 0);
    check({tag, " done"}, int'(done), 0);
    check({tag, " err_timeout"}, int'(err), 0);
    check({tag, " req_ready"}, int'(req_ready), 1);
  endtask

  typedef struct {
    logic [2:0] c;
    int         npix;
    int         exp_we;
    int         px0;
    int         px15;
  } vec_t;

  vec_t tbl [7];

  initial begin
    automatic bit ok, got;
    automatic int d0, w0, c0, l0, le0, log0, idx;
    automatic int cmds [4] = '{0, 2, 5, 6};

    tbl[0] = '{CMD_LOAD,     16, 16,  0, 54};
    tbl[1] = '{CMD_ZOOM_IN,  16, 16, 18, 45};
    tbl[2] = '{CMD_SHIFT_R,  16, 16, 19, 46};
    tbl[3] = '{CMD_SHIFT_R,  16, 16, 20, 47};
    tbl[4] = '{CMD_SHIFT_R,  16, 16, 20, 47};
    tbl[5] = '{CMD_ZOOM_OUT, 17, 16,  0, 54};
    tbl[6] = '{CMD_SHIFT_D,  16, 16,  0, 54};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // Spurious strobe while idle
    w0 = n_we;
    @(posedge clk); #1 spur_ov = 1'b1;
    @(negedge clk);
    check("idle strobe pix_we", int'(pix_we), 0);
    @(posedge clk); #1 spur_ov = 1'b0;
    check("idle strobe writes", n_we - w0, 0);

    for (int v = 0; v < 7; v++) begin
      m_npix = tbl[v].npix;
      d0 = n_done; w0 = n_we; c0 = n_cv; l0 = load_n; le0 = load_err;
      send_req(tbl[v].c, ok);
      check($sformatf("v%0d accepted", v), int'(ok), 1);
      wait_end(d0, 1'b0, got);
      check($sformatf("v%0d completed", v), int'(got), 1);
      check($sformatf("v%0d cmd_valid pulses", v), n_cv - c0, 1);
      check($sformatf("v%0d pix writes", v), n_we - w0, tbl[v].exp_we);
      check($sformatf("v%0d done pulses", v), n_done - d0, 1);
      check($sformatf("v%0d px0", v), int'(fb[0]), tbl[v].px0);
      check($sformatf("v%0d px15", v), int'(fb[15]), tbl[v].px15);
      check($sformatf("v%0d cmd held", v), int'(cmd), int'(tbl[v].c));
      if (tbl[v].c == CMD_LOAD) begin
        check($sformatf("v%0d load bytes", v), load_n - l0, 64);
        check($sformatf("v%0d load byte order", v), load_err - le0, 0);
        check($sformatf("v%0d img_addr saturated", v), int'(img_addr), 63);
      end
    end

    // Back-to-back requests with req_valid held high
    d0 = n_done; c0 = n_cv; log0 = cmd_log.size(); idx = 0;
    m_npix = 16;
    @(posedge clk); #1;
    req_cmd = cmds[0];
    req_valid = 1'b1;
    for (int n = 0; n < 5000 && idx < 4; n++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk); #1;
        idx++;
        if (idx < 4) req_cmd = cmds[idx];
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check("b2b accepted", idx, 4);
    for (int n = 0; n < 3000 && (n_done - d0) < 4; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b cmd_valid pulses", n_cv - c0, 4);
    check("b2b done pulses", n_done - d0, 4);
    check("b2b logged", cmd_log.size() - log0, 4);
    for (int i = 0; i < 4; i++) begin
      if (log0 + i < cmd_log.size())
        check($sformatf("b2b cmd%0d", i), cmd_log[log0 + i], cmds[i]);
    end
    check("b2b last px0", int'(fb[0]), 11);
    check("ready while busy", rdy_viol, 0);

    // Controller never responds
    m_npix = 0;
    d0 = n_done; w0 = n_we;
    send_req(CMD_REFRESH, ok);
    check("to accepted", int'(ok), 1);
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (err) break;
    end
    check("to raised", int'(err), 1);
    check("to latency", cyc - cv_cyc, TIMEOUT + 1);
    check("to no done", n_done - d0, 0);
    check("to no writes", n_we - w0, 0);
    m_npix = 16;
    d0 = n_done;
    send_req(CMD_SHIFT_R, ok);
    check("to recover accepted", int'(ok), 1);
    wait_end(d0, 1'b1, got);
    check("to recover done", n_done - d0, 1);
    check("to sticky", int'(err), 1);
    check("to recover px0", int'(fb[0]), 12);

    // Reset in the cycle carrying byte 30
    d0 = n_done;
    send_req(CMD_LOAD, ok);
    repeat (31) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midload datain k30", int'(datain), 30);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_idle_zero("midload reset");
    check("midload no done", n_done - d0, 0);

    d0 = n_done; w0 = n_we; l0 = load_n; le0 = load_err;
    send_req(CMD_LOAD, ok);
    wait_end(d0, 1'b0, got);
    check("reload done", n_done - d0, 1);
    check("reload bytes", load_n - l0, 64);
    check("reload byte order", load_err - le0, 0);
    check("reload writes", n_we - w0, 16);
    check("reload px0", int'(fb[0]), 0);
    check("reload px15", int'(fb[15]), 54);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
